bp_unit: RTL
============

Name: bp_unit

Overview:
- Parametrised branch-prediction unit for the frontend; successor to the fixed bp_ctl_t / bp_result_t scheme.
- Each lookup is steered by bp_ctl (00 BTB, 01 BHT, 10 RAS, 11 none) to one of three predictors:
  - BHT: array of 2-bit saturating counters.
  - BTB: direct-mapped, tagged.
  - RAS: circular return-address stack.
- Lookups are registered, giving a one-cycle prediction. Updates from the branch unit retrain the BHT and BTB.

Parameters:
- VLEN, 64, virtual address width.
- BHT_ENTRIES, 64, number of BHT counters; power of 2, ≥ 2.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, ≥ 2.
- RAS_DEPTH, 4, number of RAS slots; power of 2, ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drops the in-flight prediction; predictor tables are kept.
- lookup_valid_i  in  1  lookup request.
- lookup_ctl_i  in  4  {bp_ctl_i[1:0], ras_ctl[1:0]}.
- lookup_vpc_i  in  VLEN  PC of the control-flow instruction.
- lookup_tgt_i  in  VLEN  predecoded direct target, used in BHT mode.
- lookup_ret_i  in  VLEN  return address to push (vpc+4 or vpc+2).
- pred_valid_o  out  1  prediction is taken/valid.
- pred_addr_o  out  VLEN  predicted target.
- upd_valid_i  in  1  resolved-branch update.
- upd_ctl_i  in  2  bp_ctl of the resolved instruction.
- upd_vpc_i  in  VLEN  PC of the resolved instruction.
- upd_addr_i  in  VLEN  resolved target.
- upd_taken_i  in  1  resolved direction.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - pred_valid_o=0, pred_addr_o=0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - RAS top pointer = 0, occupancy count = 0.
- Indexing:
  - BHT index = vpc[log2(BHT_ENTRIES):1]; bit 0 is ignored.
  - BTB index is formed the same way from BTB_ENTRIES; the tag is the full vpc.
- Latency: a lookup accepted in cycle N drives pred_* in cycle N+1 for exactly one cycle. With no lookup, pred_valid_o=0 the next cycle.
- Prediction by mode:
  - BTB (00): on hit (valid and tag match), pred_valid=1 and pred_addr=stored target. On miss, pred_valid=0.
  - BHT (01): pred_valid = counter[1], pred_addr = lookup_tgt_i.
  - RAS (10): depends on ras_ctl.
    - 00 push: push lookup_ret_i; pred_valid=0.
    - 01 pop: pred_valid = (count≠0), pred_addr = top entry, then pop.
    - 10 push+pop (coroutine): predict the old top, then overwrite the top with lookup_ret_i. Count is unchanged, except that an empty stack becomes count=1.
    - 11: no operation.
  - None (11): pred_valid=0.
- RAS boundaries:
  - Push when full: the pointer wraps, overwriting the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: pred_valid=0 and the pointer is unchanged.
- Updates (upd_valid_i):
  - ctl 01: counter increments (saturating at 11) if taken, otherwise decrements (saturating at 00).
  - ctl 00: write BTB {valid=1, tag=vpc, target=upd_addr_i}.
  - ctl 10 and 11: no table change.
- Lookup and update in the same cycle to the same entry: the lookup sees the pre-update value (read-before-write). The update still takes effect.
- flush_i:
  - Forces pred_valid_o=0 in the next cycle.
  - A lookup presented in the same cycle as flush_i is discarded; it makes no RAS change.

Optional Feature:
- Macro BP_UNIT_GSHARE_EN.
- Defined:
  - Adds a log2(BHT_ENTRIES)-bit global history register, reset to 0.
  - On every ctl=01 update, the register shifts left and takes upd_taken_i as its LSB.
  - BHT lookup and update index = pc-index XOR ghr. The update uses the ghr value from before its own shift.
- Undefined: BHT indexing is PC-only and no history register exists.

Decomposition:
- bp_pkg holds:
  - bp_ctl_t and the bp_mode_e enum (BTB/BHT/RAS/NONE).
  - The ras_op_e enum (PUSH/POP/PUSHPOP/NOP).
  - bp_result_t.
  - The counter reset constant 2'b01.
- One sub-module, bp_ras: the circular stack with push/pop/pushpop and occupancy count.
- BHT and BTB stay inline as arrays.

Test Plan:
- Reset, then BHT lookup at vpc=0x80000010 with tgt=0x80000100 → next cycle pred_valid=0.
  - Two taken updates at that vpc, then a new lookup → pred_valid=1, pred_addr=0x80000100.
- BTB update vpc=0x1000, addr=0x2000. Lookup 0x1000 → hit 0x2000. Lookup 0x1040 (same index, different tag) → pred_valid=0.
- RAS with DEPTH=4: push 0xA, 0xB, 0xC, 0xD, 0xE, then pop ×5 → 0xE, 0xD, 0xC, 0xB valid; the fifth pop gives pred_valid=0.
- RAS pushpop on stack [0xA]: ret=0xB → predicts 0xA; a following pop predicts 0xB. Pop on an empty stack → pred_valid=0, pointer unchanged.
- Lookup and flush_i in the same cycle (RAS push 0x44) → pred_valid=0 next cycle; a following pop on the previously empty stack gives pred_valid=0.
- Assert rst_ni mid-sequence after training → all outputs 0 immediately; BTB miss and BHT weakly not-taken after release. With BP_UNIT_GSHARE_EN defined, a T,N alternating pattern at one PC is learned to 100% after warm-up.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch prediction unit
package bp_pkg;

  // Raw predictor-select field as carried by the frontend and branch unit.
  typedef logic [1:0] bp_ctl_t;

  typedef enum logic [1:0] {
    BP_BTB  = 2'b00,
    BP_BHT  = 2'b01,
    BP_RAS  = 2'b10,
    BP_NONE = 2'b11
  } bp_mode_e;

  typedef enum logic [1:0] {
    RAS_PUSH    = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSHPOP = 2'b10,
    RAS_NOP     = 2'b11
  } ras_op_e;

  // Fixed 64-bit result record kept for consumers of the previous interface.
  localparam int BP_ADDR_W = 64;

  typedef struct packed {
    logic                 valid;
    logic [BP_ADDR_W-1:0] addr;
  } bp_result_t;

  // Counters start weakly not-taken so one taken update flips the prediction.
  localparam logic [1:0] BHT_CNT_RESET = 2'b01;

  // Two-bit saturating counter step.
  function automatic logic [1:0] bht_cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11) nxt = cnt + 2'b01;
    else if (!taken && cnt != 2'b00) nxt = cnt - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// rtl/bp_ras.sv - circular return-address stack with occupancy count
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, pop_i   push, pop; both together = overwrite top (coroutine)
//   data_i          return address to write
//   top_o           current top entry (valid only when !empty_o)
//   empty_o         occupancy count is zero
module bp_ras
  import bp_pkg::*;
#(
  parameter int VLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VLEN-1:0] stack_q [DEPTH];
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign top_o   = stack_q[ptr_q];
  assign empty_o = (cnt_q == '0);

  // ptr_q always addresses the current top; a push pre-increments it so a
  // full stack simply wraps onto the oldest slot.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (push_i) begin
      ptr_d  = ptr_q + PW'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) stack_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/bp_unit.sv
// rtl/bp_unit.sv - branch prediction unit (BHT, BTB, RAS), one-cycle registered prediction
//
// Optional feature: define BP_UNIT_GSHARE_EN to XOR a global history register
// into the BHT index.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              discard the lookup of this cycle, clear next prediction
//   lookup_valid_i       lookup request
//   lookup_ctl_i         {bp_ctl[1:0], ras_op[1:0]}
//   lookup_vpc_i         PC of the control-flow instruction
//   lookup_tgt_i         predecoded direct target (BHT mode)
//   lookup_ret_i         return address to push (RAS mode)
//   pred_valid_o         prediction taken/valid, one cycle after the lookup
//   pred_addr_o          predicted target
//   upd_valid_i          resolved-branch update
//   upd_ctl_i            bp_ctl of the resolved instruction
//   upd_vpc_i            PC of the resolved instruction
//   upd_addr_i           resolved target
//   upd_taken_i          resolved direction
module bp_unit
  import bp_pkg::*;
#(
  parameter int VLEN        = 64,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [3:0]      lookup_ctl_i,
  input  logic [VLEN-1:0] lookup_vpc_i,
  input  logic [VLEN-1:0] lookup_tgt_i,
  input  logic [VLEN-1:0] lookup_ret_i,
  output logic            pred_valid_o,
  output logic [VLEN-1:0] pred_addr_o,
  input  logic            upd_valid_i,
  input  logic [1:0]      upd_ctl_i,
  input  logic [VLEN-1:0] upd_vpc_i,
  input  logic [VLEN-1:0] upd_addr_i,
  input  logic            upd_taken_i
);

  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int BTB_IW = $clog2(BTB_ENTRIES);

  logic [1:0]             bht_q [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [VLEN-1:0]        btb_tag_q [BTB_ENTRIES];
  logic [VLEN-1:0]        btb_tgt_q [BTB_ENTRIES];

  logic            pred_valid_q, pred_valid_d;
  logic [VLEN-1:0] pred_addr_q, pred_addr_d;

  bp_mode_e        lk_mode;
  ras_op_e         lk_rop;
  bp_mode_e        upd_mode;
  logic            lk_fire;
  logic            upd_bht, upd_btb;
  logic [BHT_IW-1:0] bht_lk_idx, bht_up_idx;
  logic [BTB_IW-1:0] btb_lk_idx, btb_up_idx;

  logic            ras_push, ras_pop, ras_empty;
  logic [VLEN-1:0] ras_top;

  assign lk_mode  = bp_mode_e'(lookup_ctl_i[3:2]);
  assign lk_rop   = ras_op_e'(lookup_ctl_i[1:0]);
  assign upd_mode = bp_mode_e'(upd_ctl_i);
  assign lk_fire  = lookup_valid_i && !flush_i;
  assign upd_bht  = upd_valid_i && (upd_mode == BP_BHT);
  assign upd_btb  = upd_valid_i && (upd_mode == BP_BTB);

  // PC bit 0 never distinguishes instructions, so indexing starts at bit 1.
  assign btb_lk_idx = lookup_vpc_i[BTB_IW:1];
  assign btb_up_idx = upd_vpc_i[BTB_IW:1];

`ifdef BP_UNIT_GSHARE_EN
  logic [BHT_IW-1:0] ghr_q;

  assign bht_lk_idx = lookup_vpc_i[BHT_IW:1] ^ ghr_q;
  // Uses the history from before this update's own shift.
  assign bht_up_idx = upd_vpc_i[BHT_IW:1] ^ ghr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else if (upd_bht) begin
      ghr_q <= (ghr_q << 1) | BHT_IW'(upd_taken_i);
    end
  end
`else
  assign bht_lk_idx = lookup_vpc_i[BHT_IW:1];
  assign bht_up_idx = upd_vpc_i[BHT_IW:1];
`endif

  // Table reads happen before the clock edge that applies any same-cycle
  // update, which gives read-before-write without extra bypass logic.
  always_comb begin
    pred_valid_d = 1'b0;
    pred_addr_d  = '0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    if (lk_fire) begin
      case (lk_mode)
        BP_BTB: begin
          if (btb_valid_q[btb_lk_idx] && btb_tag_q[btb_lk_idx] == lookup_vpc_i) begin
            pred_valid_d = 1'b1;
            pred_addr_d  = btb_tgt_q[btb_lk_idx];
          end
        end
        BP_BHT: begin
          pred_valid_d = bht_q[bht_lk_idx][1];
          pred_addr_d  = lookup_tgt_i;
        end
        BP_RAS: begin
          case (lk_rop)
            RAS_PUSH: ras_push = 1'b1;
            RAS_POP: begin
              ras_pop      = 1'b1;
              pred_valid_d = !ras_empty;
              pred_addr_d  = ras_top;
            end
            RAS_PUSHPOP: begin
              ras_push     = 1'b1;
              ras_pop      = 1'b1;
              pred_valid_d = !ras_empty;
              pred_addr_d  = ras_top;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_q <= 1'b0;
      pred_addr_q  <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_addr_q  <= pred_addr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_CNT_RESET;
      btb_valid_q <= '0;
    end else begin
      if (upd_bht) bht_q[bht_up_idx] <= bht_cnt_next(bht_q[bht_up_idx], upd_taken_i);
      if (upd_btb) btb_valid_q[btb_up_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (upd_btb) begin
      btb_tag_q[btb_up_idx] <= upd_vpc_i;
      btb_tgt_q[btb_up_idx] <= upd_addr_i;
    end
  end

  bp_ras #(
    .VLEN  (VLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (lookup_ret_i),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

  assign pred_valid_o = pred_valid_q;
  assign pred_addr_o  = pred_addr_q;

endmodule
